// File: rtl/dff_pkg.sv
// Shared defaults and sizing helper for the dff_pipe retiming/buffering slice.
package dff_pkg;

  localparam int unsigned DFF_PIPE_WIDTH_DEF = 8;
  localparam int unsigned DFF_PIPE_DEPTH_DEF = 3;

  // Bits needed to hold an occupancy of 0..depth (never less than one bit).
  function automatic int unsigned clog2_count(input int unsigned depth);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) > depth) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready handshake bundle for dff_pipe: upstream push side, downstream pop side and occupancy.
interface dff_pipe_if import dff_pkg::*; #(
  parameter int unsigned WIDTH = DFF_PIPE_WIDTH_DEF,
  parameter int unsigned DEPTH = DFF_PIPE_DEPTH_DEF
);

  localparam int unsigned CW = clog2_count(DEPTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One {valid,data} pipeline slot: async reset, global enable, synchronous flush of valid, ready-gated load.
module dff_pipe_stage import dff_pkg::*; #(
  parameter int unsigned          WIDTH       = DFF_PIPE_WIDTH_DEF,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             rdy_in,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic load;

  // The slot can take a new value when it is empty or whatever it holds moves on.
  assign load = en & ~flush & (~valid | rdy_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (en && flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble collapsing, enable, flush and occupancy count.
module dff_pipe import dff_pkg::*; #(
  parameter int unsigned      WIDTH       = DFF_PIPE_WIDTH_DEF,
  parameter int unsigned      DEPTH       = DFF_PIPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  dff_pipe_if.slave  bus
);

  localparam int unsigned CW = clog2_count(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] rdy_next;
  logic             active;
  logic             in_ready;
  logic             out_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count;

  assign active = en & ~flush;

  // Ready seen by stage i from downstream: the output is taken or some later slot
  // is empty. Flattened from the valid bits so the chain forms no combinational loop.
  always_comb begin
    rdy_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdy_next[i] = bus.out_ready;
      for (int unsigned j = i + 1; j < DEPTH; j++) begin
        if (!valid[j]) rdy_next[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;

    if (i == 0) begin : g_head
      assign prev_valid = bus.in_valid;
      assign prev_data  = bus.in_data;
    end else begin : g_body
      assign prev_valid = valid[i-1];
      assign prev_data  = data[i-1];
    end

    dff_pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .flush      (flush),
      .rdy_in     (rdy_next[i]),
      .prev_valid (prev_valid),
      .prev_data  (prev_data),
      .valid      (valid[i]),
      .data       (data[i])
    );
  end

  assign in_ready  = (~valid[0] | rdy_next[0]) & active & ~rst;
  assign out_valid = valid[DEPTH-1] & active;
  assign in_xfer   = bus.in_valid & in_ready;
  assign out_xfer  = out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (flush) begin
        count <= '0;
      end else if (in_xfer && !out_xfer) begin
        count <= count + CW'(1);
      end else if (out_xfer && !in_xfer) begin
        count <= count - CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data[DEPTH-1];
  assign bus.count     = count;

endmodule
